// File: rtl/xdma_dsc_byp_sched_if.sv
// Signal bundle between the user-side requesters, the bypass scheduler and the
// XDMA descriptor-bypass port. The master modport is the scheduler's view.
interface xdma_dsc_byp_sched_if #(
   parameter int NUM_REQ = 4,
   parameter int IDW     = 2
);
   logic                    en;
   logic [NUM_REQ-1:0]      req_valid;
   logic [NUM_REQ-1:0]      req_ready;
   logic [NUM_REQ*64-1:0]   req_src_addr;
   logic [NUM_REQ*64-1:0]   req_dst_addr;
   logic [NUM_REQ*28-1:0]   req_len;
   logic                    dsc_byp_load;
   logic [63:0]             dsc_byp_src_addr;
   logic [63:0]             dsc_byp_dst_addr;
   logic [27:0]             dsc_byp_len;
   logic [15:0]             dsc_byp_ctl;
   logic                    dsc_byp_ready;
   logic                    done_valid;
   logic [IDW-1:0]          done_id;
   logic                    busy;

   modport master (
      input  en, req_valid, req_src_addr, req_dst_addr, req_len, dsc_byp_ready,
      output req_ready, dsc_byp_load, dsc_byp_src_addr, dsc_byp_dst_addr,
             dsc_byp_len, dsc_byp_ctl, done_valid, done_id, busy
   );

   modport slave (
      output en, req_valid, req_src_addr, req_dst_addr, req_len, dsc_byp_ready,
      input  req_ready, dsc_byp_load, dsc_byp_src_addr, dsc_byp_dst_addr,
             dsc_byp_len, dsc_byp_ctl, done_valid, done_id, busy
   );
endinterface

// File: rtl/xdma_dsc_byp_sched.sv
// Round-robin scheduler sharing one XDMA descriptor-bypass channel among
// NUM_REQ requesters; long transfers are split into MAX_CHUNK descriptors.
module xdma_dsc_byp_sched #(
   parameter int NUM_REQ   = 4,
   parameter int MAX_CHUNK = 4096,
   parameter int IDW       = 2
) (
   input  logic                 axi_aclk,
   input  logic                 axi_aresetn,
   xdma_dsc_byp_sched_if.master bus
);

   localparam logic [27:0] CHUNK   = 28'(MAX_CHUNK);
   localparam logic [63:0] CHUNK64 = 64'(MAX_CHUNK);

   typedef enum logic {IDLE, ISSUE} state_t;

   state_t             state_reg;
   logic [IDW-1:0]     last_grant_reg;
   logic [IDW-1:0]     cur_id_reg;
   logic [63:0]        cur_src_reg;
   logic [63:0]        cur_dst_reg;
   logic [27:0]        rem_reg;
   logic [27:0]        len_reg;
   logic               last_reg;
   logic               load_reg;
   logic               done_valid_reg;
   logic [IDW-1:0]     done_id_reg;

   logic [63:0]        req_src [NUM_REQ];
   logic [63:0]        req_dst [NUM_REQ];
   logic [27:0]        req_len [NUM_REQ];

   logic               win_found;
   logic [IDW-1:0]     win_idx;
   int                 arb_idx;
   logic [NUM_REQ-1:0] grant_onehot;
   logic               accept;
   logic [63:0]        sel_src;
   logic [63:0]        sel_dst;
   logic [27:0]        sel_len;
   logic [27:0]        rem_next;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign req_src[gi] = bus.req_src_addr[64*gi +: 64];
         assign req_dst[gi] = bus.req_dst_addr[64*gi +: 64];
         assign req_len[gi] = bus.req_len[28*gi +: 28];
      end
   endgenerate

   function automatic logic [27:0] chunk_of(input logic [27:0] r);
      return (r > CHUNK) ? CHUNK : r;
   endfunction

   // Search starts one past the previous winner so every requester is served in turn.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      arb_idx   = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         arb_idx = int'(last_grant_reg) + 1 + k;
         if (arb_idx >= NUM_REQ) begin
            arb_idx = arb_idx - NUM_REQ;
         end
         if (!win_found && bus.req_valid[arb_idx]) begin
            win_found = 1'b1;
            win_idx   = IDW'(arb_idx);
         end
      end
   end

   always_comb begin
      grant_onehot = '0;
      if (state_reg == IDLE && bus.en && win_found) begin
         grant_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
      end
   end

   assign accept   = |(bus.req_valid & grant_onehot);
   assign sel_src  = req_src[win_idx];
   assign sel_dst  = req_dst[win_idx];
   assign sel_len  = req_len[win_idx];
   assign rem_next = rem_reg - CHUNK;

   always_ff @(posedge axi_aclk) begin
      if (!axi_aresetn) begin
         state_reg      <= IDLE;
         last_grant_reg <= IDW'(NUM_REQ - 1);
         cur_id_reg     <= '0;
         cur_src_reg    <= '0;
         cur_dst_reg    <= '0;
         rem_reg        <= '0;
         len_reg        <= '0;
         last_reg       <= 1'b0;
         load_reg       <= 1'b0;
         done_valid_reg <= 1'b0;
         done_id_reg    <= '0;
      end else begin
         done_valid_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  cur_src_reg    <= sel_src;
                  cur_dst_reg    <= sel_dst;
                  rem_reg        <= sel_len;
                  len_reg        <= chunk_of(sel_len);
                  last_reg       <= (sel_len <= CHUNK);
                  last_grant_reg <= win_idx;
                  cur_id_reg     <= win_idx;
                  if (sel_len != 28'd0) begin
                     state_reg <= ISSUE;
                     load_reg  <= 1'b1;
                  end else begin
                     // Zero-length request completes immediately without a descriptor.
                     done_valid_reg <= 1'b1;
                     done_id_reg    <= win_idx;
                  end
               end
            end
            ISSUE: begin
               if (load_reg && bus.dsc_byp_ready) begin
                  if (last_reg) begin
                     state_reg      <= IDLE;
                     load_reg       <= 1'b0;
                     done_valid_reg <= 1'b1;
                     done_id_reg    <= cur_id_reg;
                  end else begin
                     rem_reg     <= rem_next;
                     cur_src_reg <= cur_src_reg + CHUNK64;
                     cur_dst_reg <= cur_dst_reg + CHUNK64;
                     len_reg     <= chunk_of(rem_next);
                     last_reg    <= (rem_next <= CHUNK);
                  end
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign bus.req_ready        = grant_onehot;
   assign bus.dsc_byp_load     = load_reg;
   assign bus.dsc_byp_src_addr = cur_src_reg;
   assign bus.dsc_byp_dst_addr = cur_dst_reg;
   assign bus.dsc_byp_len      = len_reg;
   assign bus.dsc_byp_ctl      = {11'b0, load_reg & last_reg, 2'b0, load_reg & last_reg, 1'b0};
   assign bus.done_valid       = done_valid_reg;
   assign bus.done_id          = done_id_reg;
   assign bus.busy             = (state_reg == ISSUE);

endmodule

// File: tb/tb_xdma_dsc_byp_sched.sv
// Directed bench for the descriptor-bypass scheduler: single, split with
// address wrap, backpressure, round-robin, zero-length, enable and reset cases.
module tb_xdma_dsc_byp_sched;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   xdma_dsc_byp_sched_if #(.NUM_REQ(4), .IDW(2)) bus ();

   xdma_dsc_byp_sched #(.NUM_REQ(4), .MAX_CHUNK(4096), .IDW(2)) dut (
      .axi_aclk    (clk),
      .axi_aresetn (rstn),
      .bus         (bus)
   );

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int i, input logic [63:0] s, input logic [63:0] d,
                          input logic [27:0] l);
      bus.req_src_addr[64*i +: 64] = s;
      bus.req_dst_addr[64*i +: 64] = d;
      bus.req_len[28*i +: 28]      = l;
   endtask

   task automatic chk_desc(input string tag, input logic [63:0] s, input logic [63:0] d,
                           input logic [27:0] l, input logic [15:0] c);
      chk({tag, "_load"}, 64'(bus.dsc_byp_load), 64'd1);
      chk({tag, "_src"},  bus.dsc_byp_src_addr, s);
      chk({tag, "_dst"},  bus.dsc_byp_dst_addr, d);
      chk({tag, "_len"},  64'(bus.dsc_byp_len), 64'(l));
      chk({tag, "_ctl"},  64'(bus.dsc_byp_ctl), 64'(c));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int rr_exp [5];
      rr_exp = '{0, 1, 2, 3, 0};

      bus.en            = 1'b0;
      bus.req_valid     = '0;
      bus.req_src_addr  = '0;
      bus.req_dst_addr  = '0;
      bus.req_len       = '0;
      bus.dsc_byp_ready = 1'b1;

      // Reset state
      tick; tick;
      chk("rst_load",  64'(bus.dsc_byp_load), 64'd0);
      chk("rst_done",  64'(bus.done_valid), 64'd0);
      chk("rst_busy",  64'(bus.busy), 64'd0);
      chk("rst_src",   bus.dsc_byp_src_addr, 64'd0);
      chk("rst_len",   64'(bus.dsc_byp_len), 64'd0);
      chk("rst_ctl",   64'(bus.dsc_byp_ctl), 64'd0);
      chk("rst_did",   64'(bus.done_id), 64'd0);
      rstn = 1'b1;
      tick;

      // Single descriptor transfer, len == MAX_CHUNK
      bus.en = 1'b1;
      set_req(0, 64'h1000, 64'h8000_0000, 28'd4096);
      bus.req_valid = 4'b0001;
      #1 chk("single_rdy", 64'(bus.req_ready), 64'h1);
      tick;
      bus.req_valid = '0;
      chk_desc("single_d0", 64'h1000, 64'h8000_0000, 28'd4096, 16'h0012);
      chk("single_busy", 64'(bus.busy), 64'd1);
      chk("single_rdy_issue", 64'(bus.req_ready), 64'h0);
      tick;
      chk("single_load_off", 64'(bus.dsc_byp_load), 64'd0);
      chk("single_done", 64'(bus.done_valid), 64'd1);
      chk("single_did", 64'(bus.done_id), 64'd0);
      tick;
      chk("single_done_pulse", 64'(bus.done_valid), 64'd0);

      // Split 10000 bytes with destination wrap and a 5-cycle stall on chunk 2
      set_req(1, 64'h2000, 64'hFFFF_FFFF_FFFF_F000, 28'd10000);
      bus.req_valid = 4'b0010;
      #1 chk("split_rdy", 64'(bus.req_ready), 64'h2);
      tick;
      bus.req_valid = '0;
      chk_desc("split_d0", 64'h2000, 64'hFFFF_FFFF_FFFF_F000, 28'd4096, 16'h0000);
      tick;
      chk_desc("split_d1", 64'h3000, 64'h0, 28'd4096, 16'h0000);
      chk("split_nodone1", 64'(bus.done_valid), 64'd0);
      bus.dsc_byp_ready = 1'b0;
      for (int s = 0; s < 5; s++) begin
         tick;
         chk_desc("stall_d1", 64'h3000, 64'h0, 28'd4096, 16'h0000);
      end
      bus.dsc_byp_ready = 1'b1;
      tick;
      chk_desc("split_d2", 64'h4000, 64'h1000, 28'd1808, 16'h0012);
      chk("split_nodone2", 64'(bus.done_valid), 64'd0);
      tick;
      chk("split_load_off", 64'(bus.dsc_byp_load), 64'd0);
      chk("split_done", 64'(bus.done_valid), 64'd1);
      chk("split_did", 64'(bus.done_id), 64'd1);
      tick;
      chk("split_done_pulse", 64'(bus.done_valid), 64'd0);

      // Round-robin from a fresh reset, all requesters held
      rstn = 1'b0;
      tick;
      rstn = 1'b1;
      for (int i = 0; i < 4; i++) begin
         set_req(i, 64'h10000 * (i + 1), 64'h20000 * (i + 1), 28'd64);
      end
      bus.req_valid = 4'b1111;
      for (int t = 0; t < 5; t++) begin
         #1 chk($sformatf("rr%0d_rdy", t), 64'(bus.req_ready), 64'(1) << rr_exp[t]);
         tick;
         if (t == 4) bus.req_valid = '0;
         chk_desc($sformatf("rr%0d", t), 64'h10000 * (rr_exp[t] + 1),
                  64'h20000 * (rr_exp[t] + 1), 28'd64, 16'h0012);
         tick;
         chk($sformatf("rr%0d_done", t), 64'(bus.done_valid), 64'd1);
         chk($sformatf("rr%0d_did", t), 64'(bus.done_id), 64'(rr_exp[t]));
      end
      tick;
      chk("rr_done_pulse", 64'(bus.done_valid), 64'd0);

      // Zero-length request
      set_req(2, 64'hABC0, 64'hDEF0, 28'd0);
      bus.req_valid = 4'b0100;
      #1 chk("zero_rdy", 64'(bus.req_ready), 64'h4);
      tick;
      bus.req_valid = '0;
      chk("zero_load", 64'(bus.dsc_byp_load), 64'd0);
      chk("zero_done", 64'(bus.done_valid), 64'd1);
      chk("zero_did", 64'(bus.done_id), 64'd2);
      chk("zero_busy", 64'(bus.busy), 64'd0);
      tick;
      chk("zero_done_pulse", 64'(bus.done_valid), 64'd0);
      chk("zero_load2", 64'(bus.dsc_byp_load), 64'd0);

      // Enable low blocks grants
      bus.en = 1'b0;
      for (int i = 0; i < 4; i++) set_req(i, 64'h100, 64'h200, 28'd64);
      bus.req_valid = 4'b1111;
      for (int s = 0; s < 4; s++) begin
         #1 chk("en0_rdy", 64'(bus.req_ready), 64'h0);
         tick;
         chk("en0_busy", 64'(bus.busy), 64'd0);
         chk("en0_load", 64'(bus.dsc_byp_load), 64'd0);
      end
      bus.req_valid = '0;

      // Reset during the second chunk abandons the transfer
      bus.en = 1'b1;
      set_req(0, 64'h5000, 64'h9000, 28'd10000);
      bus.req_valid = 4'b0001;
      tick;
      bus.req_valid = '0;
      chk_desc("rstmid_d0", 64'h5000, 64'h9000, 28'd4096, 16'h0000);
      tick;
      chk_desc("rstmid_d1", 64'h6000, 64'hA000, 28'd4096, 16'h0000);
      rstn = 1'b0;
      tick;
      rstn = 1'b1;
      chk("rstmid_load", 64'(bus.dsc_byp_load), 64'd0);
      chk("rstmid_busy", 64'(bus.busy), 64'd0);
      chk("rstmid_done", 64'(bus.done_valid), 64'd0);
      chk("rstmid_src", bus.dsc_byp_src_addr, 64'd0);
      set_req(2, 64'h7000, 64'h7800, 28'd32);
      set_req(0, 64'h3000, 64'h3800, 28'd16);
      bus.req_valid = 4'b0101;
      #1 chk("rstmid_rdy", 64'(bus.req_ready), 64'h1);
      tick;
      bus.req_valid = 4'b0100;
      chk("rstmid_nodone", 64'(bus.done_valid), 64'd0);
      chk_desc("rstmid_g0", 64'h3000, 64'h3800, 28'd16, 16'h0012);
      tick;
      bus.req_valid = '0;
      chk("rstmid_g0_done", 64'(bus.done_valid), 64'd1);
      chk("rstmid_g0_did", 64'(bus.done_id), 64'd0);
      tick;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
